// File: rtl/l1i_cache_if.sv
// l1i_cache_if: fetch, refill, preload and result bundle for the L1
// instruction cache. Vectors are [0:N-1] with bit 0 as the MSB.
//
// Handshake:
//  - fetchEnable_i is the request valid.
//  - The cache takes a request on any clock edge where all of these hold:
//    fetchStall_i=0, the cache is not waiting for a refill, and no miss is
//    being reported on that edge. There is no ready output, so the fetch
//    side learns the outcome only from the result pulses.
//  - outputEnable_o is the result valid (one bundle). cacheMiss_o is the
//    miss-report valid. Both are plain pulses; the only back-pressure is
//    fetchStall_i, which holds them.
//  - cacheUpdate_i and naturalWriteEn_i are single-cycle write strobes.
//
// Ports
//  master : fetch/refill side (drives the *_i signals)
//  slave  : the cache (drives the *_o signals and fsm_state)
//  fsm_state is 1 while the cache is waiting for a refill.
interface l1i_cache_if;
  logic          fetchEnable_i;
  logic          fetchStall_i;
  logic [0:19]   Pid_i;
  logic [0:15]   Tid_i;
  logic [0:49]   tag_i;
  logic [0:7]    index_i;
  logic [0:5]    offset_i;

  logic          cacheUpdate_i;
  logic [0:63]   cacheUpdateAddress_i;
  logic [0:19]   cacheUpdatePid_i;
  logic [0:15]   cacheUpdateTid_i;
  logic [0:511]  cacheUpdateLine1_i;

  logic          naturalWriteEn_i;
  logic [0:63]   naturalWriteAddress_i;
  logic [0:511]  naturalWriteLine_i;
  logic [0:19]   naturalPid_i;
  logic [0:15]   naturalTid_i;

  logic          outputEnable_o;
  logic [0:127]  outputBundle_o;
  logic [0:63]   bundleAddress_o;
  logic [0:2]    bundleLen_o;
  logic [0:19]   bundlePid_o;
  logic [0:15]   bundleTid_o;
  logic [0:63]   bundleStartMajId_o;

  logic          cacheMiss_o;
  logic [0:63]   missedAddress_o;
  logic [0:63]   missedInstMajorId_o;
  logic [0:19]   missedPid_o;
  logic [0:15]   missedTid_o;

  logic          fsm_state;

  modport master (
    output fetchEnable_i, fetchStall_i, Pid_i, Tid_i, tag_i, index_i, offset_i,
           cacheUpdate_i, cacheUpdateAddress_i, cacheUpdatePid_i, cacheUpdateTid_i,
           cacheUpdateLine1_i, naturalWriteEn_i, naturalWriteAddress_i,
           naturalWriteLine_i, naturalPid_i, naturalTid_i,
    input  outputEnable_o, outputBundle_o, bundleAddress_o, bundleLen_o,
           bundlePid_o, bundleTid_o, bundleStartMajId_o, cacheMiss_o,
           missedAddress_o, missedInstMajorId_o, missedPid_o, missedTid_o, fsm_state
  );

  modport slave (
    input  fetchEnable_i, fetchStall_i, Pid_i, Tid_i, tag_i, index_i, offset_i,
           cacheUpdate_i, cacheUpdateAddress_i, cacheUpdatePid_i, cacheUpdateTid_i,
           cacheUpdateLine1_i, naturalWriteEn_i, naturalWriteAddress_i,
           naturalWriteLine_i, naturalPid_i, naturalTid_i,
    output outputEnable_o, outputBundle_o, bundleAddress_o, bundleLen_o,
           bundlePid_o, bundleTid_o, bundleStartMajId_o, cacheMiss_o,
           missedAddress_o, missedInstMajorId_o, missedPid_o, missedTid_o, fsm_state
  );
endinterface

// File: rtl/l1i_cache.sv
// l1i_cache: direct-mapped L1 instruction cache with 256 lines of 64 bytes.
//
// Pipeline:
//  - Stage 1 registers the fetch request together with the array read.
//  - Stage 2 compares tags and registers a bundle of up to four 32-bit words.
//  - A miss reports the address and the current major ID. It flushes
//    stage 1 and waits in MISS until cacheUpdate_i refills a line.
//  - naturalWriteEn_i preloads a line in any state.
//
// Ports
//  clock_i      : clock
//  cacheReset_i : synchronous reset, active low
//  bus          : l1i_cache_if.slave (fetch/refill/preload in, bundle/miss out)
//
// Build option: define L1I_PID_CHECK_EN to make the stored pid part of the
// hit condition. By default the pid is stored but does not affect a hit.
module l1i_cache (
  input logic        clock_i,
  input logic        cacheReset_i,
  l1i_cache_if.slave bus
);
  localparam int TAG_W  = 50;
  localparam int IDX_W  = 8;
  localparam int OFF_W  = 6;
  localparam int PID_W  = 20;
  localparam int TID_W  = 16;
  localparam int LINE_W = 512;
  localparam int MAJ_W  = 64;
  localparam int LINES  = 256;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;
  state_t state;

  logic [0:LINES-1]  valid_bits;
  logic [0:TAG_W-1]  tag_mem  [0:LINES-1];
  logic [0:PID_W-1]  pid_mem  [0:LINES-1];
  logic [0:LINE_W-1] line_mem [0:LINES-1];

  // Stage 1: registered request and array read
  logic              s1_valid;
  logic [0:TAG_W-1]  s1_tag;
  logic [0:IDX_W-1]  s1_index;
  logic [0:OFF_W-1]  s1_offset;
  logic [0:PID_W-1]  s1_pid;
  logic [0:TID_W-1]  s1_tid;
  logic              rd_valid;
  logic [0:TAG_W-1]  rd_tag;
  logic [0:PID_W-1]  rd_pid;
  logic [0:LINE_W-1] rd_line;

  logic [0:MAJ_W-1]  maj_count;

  // Write ports. A refill is only taken while waiting in MISS, and it
  // overrides a preload that targets the same index on the same edge.
  logic             upd_active;
  logic             nat_active;
  logic [0:IDX_W-1] upd_index;
  logic [0:IDX_W-1] nat_index;

  assign upd_index  = bus.cacheUpdateAddress_i[TAG_W +: IDX_W];
  assign nat_index  = bus.naturalWriteAddress_i[TAG_W +: IDX_W];
  assign upd_active = (state == MISS) && bus.cacheUpdate_i;
  assign nat_active = bus.naturalWriteEn_i && !(upd_active && (nat_index == upd_index));

  // Stage 2: hit check and bundle extraction. Word 0 is the most
  // significant word of the line; byte offset bits [4:5] are ignored.
  logic         hit;
  logic [0:3]   word_sel;
  logic [0:127] bundle;
  logic [0:2]   len;
  logic         accept;

  assign word_sel = s1_offset[0:3];

  always_comb begin
    hit = rd_valid && (rd_tag == s1_tag);
`ifdef L1I_PID_CHECK_EN
    hit = hit && (rd_pid == s1_pid);
`endif
    bundle = '0;
    for (int k = 0; k < 4; k++) begin
      if (int'(word_sel) + k < 16) begin
        bundle[32*k +: 32] = rd_line[32*(int'(word_sel) + k) +: 32];
      end
    end
    len = (word_sel <= 4'd12) ? 3'd4 : 3'(5'd16 - {1'b0, word_sel});
  end

  // A request arriving on the same edge that reports a miss is dropped.
  assign accept = (state == IDLE) && bus.fetchEnable_i && !(s1_valid && !hit);

  assign bus.fsm_state = (state == MISS);

  always_ff @(posedge clock_i) begin
    if (nat_active) begin
      tag_mem[nat_index]  <= bus.naturalWriteAddress_i[0 +: TAG_W];
      pid_mem[nat_index]  <= bus.naturalPid_i;
      line_mem[nat_index] <= bus.naturalWriteLine_i;
    end
    if (upd_active) begin
      tag_mem[upd_index]  <= bus.cacheUpdateAddress_i[0 +: TAG_W];
      pid_mem[upd_index]  <= bus.cacheUpdatePid_i;
      line_mem[upd_index] <= bus.cacheUpdateLine1_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!cacheReset_i) begin
      state                   <= IDLE;
      valid_bits              <= '0;
      maj_count               <= '0;
      s1_valid                <= 1'b0;
      s1_tag                  <= '0;
      s1_index                <= '0;
      s1_offset               <= '0;
      s1_pid                  <= '0;
      s1_tid                  <= '0;
      rd_valid                <= 1'b0;
      rd_tag                  <= '0;
      rd_pid                  <= '0;
      rd_line                 <= '0;
      bus.outputEnable_o      <= 1'b0;
      bus.outputBundle_o      <= '0;
      bus.bundleAddress_o     <= '0;
      bus.bundleLen_o         <= '0;
      bus.bundlePid_o         <= '0;
      bus.bundleTid_o         <= '0;
      bus.bundleStartMajId_o  <= '0;
      bus.cacheMiss_o         <= 1'b0;
      bus.missedAddress_o     <= '0;
      bus.missedInstMajorId_o <= '0;
      bus.missedPid_o         <= '0;
      bus.missedTid_o         <= '0;
    end else begin
      if (nat_active) valid_bits[nat_index] <= 1'b1;
      // The refill is an L2-side event and completes even under a fetch stall.
      if (upd_active) begin
        valid_bits[upd_index] <= 1'b1;
        state                 <= IDLE;
      end
      if (!bus.fetchStall_i) begin
        // The array reads see values from before any write on this edge.
        s1_valid           <= accept;
        s1_tag             <= bus.tag_i;
        s1_index           <= bus.index_i;
        s1_offset          <= bus.offset_i;
        s1_pid             <= bus.Pid_i;
        s1_tid             <= bus.Tid_i;
        rd_valid           <= valid_bits[bus.index_i];
        rd_tag             <= tag_mem[bus.index_i];
        rd_pid             <= pid_mem[bus.index_i];
        rd_line            <= line_mem[bus.index_i];
        bus.outputEnable_o <= 1'b0;
        bus.cacheMiss_o    <= 1'b0;
        if (state == IDLE && s1_valid) begin
          if (hit) begin
            bus.outputEnable_o     <= 1'b1;
            bus.outputBundle_o     <= bundle;
            bus.bundleLen_o        <= len;
            bus.bundleAddress_o    <= {s1_tag, s1_index, s1_offset};
            bus.bundlePid_o        <= s1_pid;
            bus.bundleTid_o        <= s1_tid;
            bus.bundleStartMajId_o <= maj_count;
            maj_count              <= maj_count + MAJ_W'(len);
          end else begin
            bus.cacheMiss_o         <= 1'b1;
            bus.missedAddress_o     <= {s1_tag, s1_index, s1_offset};
            bus.missedInstMajorId_o <= maj_count;
            bus.missedPid_o         <= s1_pid;
            bus.missedTid_o         <= s1_tid;
            state                   <= MISS;
          end
        end
      end
    end
  end

  // Tids and the byte offsets of write addresses are not stored.
  logic unused_bits;
  assign unused_bits = ^{bus.cacheUpdateTid_i, bus.naturalTid_i, rd_pid,
                         bus.cacheUpdateAddress_i[TAG_W+IDX_W +: OFF_W],
                         bus.naturalWriteAddress_i[TAG_W+IDX_W +: OFF_W]};
endmodule

// File: tb/tb_l1i_cache.sv
`timescale 1ns/1ps
module tb_l1i_cache;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1i_cache_if bus();
  l1i_cache dut (.clock_i(clk), .cacheReset_i(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  localparam logic [511:0] PAT = 512'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_AAAA_BBBB;

  // ---------------- reference model ----------------
  // Flat arrays indexed by line number; expected bundles are computed by
  // shifting the line as a 512-bit number.
  logic         m_valid [256];
  logic [49:0]  m_tag   [256];
  logic [19:0]  m_pid   [256];
  logic [511:0] m_line  [256];
  logic [63:0]  m_maj;

  function automatic logic m_hit(input logic [63:0] a, input logic [19:0] pid);
    int idx;
    logic h;
    idx = int'(a[13:6]);
    h = m_valid[idx] && (m_tag[idx] == a[63:14]);
`ifdef L1I_PID_CHECK_EN
    h = h && (m_pid[idx] == pid);
`else
    if (pid == 20'hFFFFF) h = h;
`endif
    return h;
  endfunction

  function automatic logic [127:0] m_bundle(input logic [511:0] line, input int w);
    logic [127:0] b;
    logic [511:0] sh;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      if (w + k < 16) begin
        sh = line >> (32 * (15 - w - k));
        b = b | (128'(sh[31:0]) << (32 * (3 - k)));
      end
    end
    return b;
  endfunction

  function automatic int m_len(input int w);
    return (w <= 12) ? 4 : 16 - w;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic m_write(input logic [63:0] a, input logic [511:0] line, input logic [19:0] pid);
    int idx;
    idx = int'(a[13:6]);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = a[63:14];
    m_pid[idx]   = pid;
    m_line[idx]  = line;
  endtask

  // ---------------- scoreboard ----------------
  logic [258:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.outputEnable_o && bus.cacheMiss_o) begin
      errors++;
      $display("FAIL exclusive_pulses: outputEnable_o=1 and cacheMiss_o=1 at %0t", $time);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fetchEnable_i = 0; bus.fetchStall_i = 0;
    bus.Pid_i = '0; bus.Tid_i = '0; bus.tag_i = '0; bus.index_i = '0; bus.offset_i = '0;
    bus.cacheUpdate_i = 0; bus.cacheUpdateAddress_i = '0; bus.cacheUpdatePid_i = '0;
    bus.cacheUpdateTid_i = '0; bus.cacheUpdateLine1_i = '0;
    bus.naturalWriteEn_i = 0; bus.naturalWriteAddress_i = '0; bus.naturalWriteLine_i = '0;
    bus.naturalPid_i = '0; bus.naturalTid_i = '0;
  endtask

  task automatic set_fetch(input logic [63:0] a, input logic [19:0] pid, input logic [15:0] tid);
    bus.fetchEnable_i = 1;
    bus.tag_i = a[63:14]; bus.index_i = a[13:6]; bus.offset_i = a[5:0];
    bus.Pid_i = pid; bus.Tid_i = tid;
  endtask

  task automatic set_nat(input logic [63:0] a, input logic [511:0] line, input logic [19:0] pid);
    bus.naturalWriteEn_i = 1; bus.naturalWriteAddress_i = a;
    bus.naturalWriteLine_i = line; bus.naturalPid_i = pid; bus.naturalTid_i = 16'h1;
  endtask

  task automatic nat_write(input logic [63:0] a, input logic [511:0] line, input logic [19:0] pid);
    set_nat(a, line, pid);
    step();
    bus.naturalWriteEn_i = 0;
    m_write(a, line, pid);
  endtask

  task automatic set_upd(input logic [63:0] a, input logic [511:0] line, input logic [19:0] pid);
    bus.cacheUpdate_i = 1; bus.cacheUpdateAddress_i = a;
    bus.cacheUpdateLine1_i = line; bus.cacheUpdatePid_i = pid; bus.cacheUpdateTid_i = 16'h2;
  endtask

  task automatic refill(input logic [63:0] a, input logic [511:0] line, input logic [19:0] pid);
    set_upd(a, line, pid);
    step();
    bus.cacheUpdate_i = 0;
    m_write(a, line, pid);
  endtask

  // One isolated fetch, checked against the model two edges later.
  task automatic check_fetch(input string nm, input logic [63:0] a, input logic [19:0] pid,
                             input logic [15:0] tid, output logic hit);
    int w;
    hit = m_hit(a, pid);
    w = int'(a[5:2]);
    set_fetch(a, pid, tid);
    step();
    bus.fetchEnable_i = 0;
    step();
    if (hit) begin
      chk({nm, "_en"}, bus.outputEnable_o, 1);
      chk({nm, "_miss"}, bus.cacheMiss_o, 0);
      chk({nm, "_bundle"}, bus.outputBundle_o, m_bundle(m_line[int'(a[13:6])], w));
      chk({nm, "_len"}, bus.bundleLen_o, m_len(w));
      chk({nm, "_addr"}, bus.bundleAddress_o, a);
      chk({nm, "_pid"}, bus.bundlePid_o, pid);
      chk({nm, "_tid"}, bus.bundleTid_o, tid);
      chk({nm, "_majid"}, bus.bundleStartMajId_o, m_maj);
      m_maj += 64'(m_len(w));
    end else begin
      chk({nm, "_miss"}, bus.cacheMiss_o, 1);
      chk({nm, "_en"}, bus.outputEnable_o, 0);
      chk({nm, "_maddr"}, bus.missedAddress_o, a);
      chk({nm, "_mmaj"}, bus.missedInstMajorId_o, m_maj);
      chk({nm, "_mpid"}, bus.missedPid_o, pid);
      chk({nm, "_mtid"}, bus.missedTid_o, tid);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0]  addr;
    logic [127:0] bundle;
    logic [2:0]   len;
    logic [63:0]  maj;
  } vec_t;
  vec_t tbl [7];

  initial begin
    logic h;
    logic [511:0] lx, ly;
    logic [127:0] ea, eb;
    logic [63:0] maj_a, a, cur_a;
    logic [258:0] e;
    logic stl, have_req;
    int issued, cyc;

    tbl[0] = '{64'h000, 128'h0, 3'd4, 64'd0};
    tbl[1] = '{64'h070, 128'hAAAABBBB_CCCCDDDD_EEEEFFFF_AAAABBBB, 3'd4, 64'd4};
    tbl[2] = '{64'h078, 128'hEEEEFFFF_AAAABBBB_00000000_00000000, 3'd2, 64'd8};
    tbl[3] = '{64'h0B4, 128'hCCCCDDDD_EEEEFFFF_AAAABBBB_00000000, 3'd3, 64'd10};
    tbl[4] = '{64'h0FC, 128'hAAAABBBB_00000000_00000000_00000000, 3'd1, 64'd13};
    tbl[5] = '{64'h12B, 128'h00000000_00000000_AAAABBBB_CCCCDDDD, 3'd4, 64'd14};
    tbl[6] = '{64'h240, 128'h0, 3'd4, 64'd18};

    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_pid[i] = '0; m_line[i] = '0;
    end
    m_maj = '0;
    clear_inputs();

    // Reset state
    rst_n = 0;
    step(); step();
    chk("rst_en", bus.outputEnable_o, 0);
    chk("rst_miss", bus.cacheMiss_o, 0);
    chk("rst_bundle", bus.outputBundle_o, 0);
    chk("rst_majid", bus.bundleStartMajId_o, 0);
    chk("rst_maddr", bus.missedAddress_o, 0);
    chk("rst_fsm", bus.fsm_state, 0);
    rst_n = 1;
    step();

    // Cold miss at address 0, then refill
    check_fetch("cold0", 64'h0, 20'd5, 16'd7, h);
    chk("cold0_fsm", bus.fsm_state, 1);
    refill(64'h0, PAT, 20'd5);
    chk("refill_fsm", bus.fsm_state, 0);

    for (int i = 0; i < 10; i++) nat_write(64'(i * 64), PAT, 20'd5);

    // Table-driven hits
    for (int i = 0; i < 7; i++) begin
      set_fetch(tbl[i].addr, 20'd5, 16'd7);
      step();
      bus.fetchEnable_i = 0;
      step();
      chk($sformatf("tbl%0d_en", i), bus.outputEnable_o, 1);
      chk($sformatf("tbl%0d_bundle", i), bus.outputBundle_o, tbl[i].bundle);
      chk($sformatf("tbl%0d_len", i), bus.bundleLen_o, tbl[i].len);
      chk($sformatf("tbl%0d_majid", i), bus.bundleStartMajId_o, tbl[i].maj);
      chk($sformatf("tbl%0d_addr", i), bus.bundleAddress_o, tbl[i].addr);
      m_maj += 64'(tbl[i].len);
    end

    // Pid mismatch: a miss only when the pid check is built in
    check_fetch("pidmm", 64'h0, 20'd9, 16'd7, h);
`ifdef L1I_PID_CHECK_EN
    chk("pidmm_is_miss", h, 0);
`else
    chk("pidmm_is_hit", h, 1);
`endif
    if (!h) refill(64'h0, m_line[0], 20'd9);

    // Miss on 0x280 with fetchEnable held: requests are ignored until refill
    set_fetch(64'h280, 20'd5, 16'd7);
    step(); step();
    chk("m280_miss", bus.cacheMiss_o, 1);
    chk("m280_mmaj", bus.missedInstMajorId_o, m_maj);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("m280_ign_en", bus.outputEnable_o, 0);
      chk("m280_ign_miss", bus.cacheMiss_o, 0);
    end
    bus.fetchEnable_i = 0;
    refill(64'h280, rand_line(), 20'd5);
    check_fetch("m280_hit", 64'h280, 20'd5, 16'd7, h);
    chk("m280_hit_flag", h, 1);

    // Read-before-write on index 11
    lx = rand_line(); ly = rand_line();
    nat_write(64'h2C0, lx, 20'd5);
    set_fetch(64'h2C4, 20'd5, 16'd7);
    set_nat(64'h2C0, ly, 20'd5);
    step();
    bus.fetchEnable_i = 0; bus.naturalWriteEn_i = 0;
    step();
    chk("rbw_old_en", bus.outputEnable_o, 1);
    chk("rbw_old_bundle", bus.outputBundle_o, m_bundle(lx, 1));
    m_maj += 64'd4;
    m_write(64'h2C0, ly, 20'd5);
    check_fetch("rbw_new", 64'h2C4, 20'd5, 16'd7, h);

    // Refill and preload to the same index: refill wins
    check_fetch("prio_miss", 64'h300, 20'd5, 16'd7, h);
    lx = rand_line(); ly = rand_line();
    set_upd(64'h300, lx, 20'd5);
    set_nat(64'h300, ly, 20'd5);
    step();
    bus.cacheUpdate_i = 0; bus.naturalWriteEn_i = 0;
    m_write(64'h300, lx, 20'd5);
    check_fetch("prio_hit", 64'h300, 20'd5, 16'd7, h);

    // Stall holds outputs and blocks new requests
    ea = m_bundle(m_line[1], 12); eb = m_bundle(m_line[3], 14); maj_a = m_maj;
    set_fetch(64'h070, m_pid[1], 16'd7);
    step();
    set_fetch(64'h0F8, m_pid[3], 16'd7);
    step();
    chk("stall_a_en", bus.outputEnable_o, 1);
    chk("stall_a_bundle", bus.outputBundle_o, ea);
    set_fetch(64'h000, m_pid[0], 16'd7);
    bus.fetchStall_i = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_hold_en", bus.outputEnable_o, 1);
      chk("stall_hold_bundle", bus.outputBundle_o, ea);
      chk("stall_hold_majid", bus.bundleStartMajId_o, maj_a);
    end
    bus.fetchStall_i = 0; bus.fetchEnable_i = 0;
    step();
    chk("stall_b_en", bus.outputEnable_o, 1);
    chk("stall_b_bundle", bus.outputBundle_o, eb);
    chk("stall_b_len", bus.bundleLen_o, 2);
    chk("stall_b_majid", bus.bundleStartMajId_o, maj_a + 64'd4);
    step();
    chk("stall_after_en", bus.outputEnable_o, 0);
    m_maj += 64'd6;

    // Back-to-back hits with random stalls through the expected queue
    issued = 0; cyc = 0; have_req = 0; cur_a = '0;
    while ((issued < 12 || exp_q.size() > 0) && cyc < 80) begin
      cyc++;
      if (!have_req && issued < 12) begin
        cur_a = {50'd0, 8'($urandom_range(0, 9)), 6'($urandom_range(0, 63))};
        have_req = 1;
      end
      stl = ($urandom_range(0, 4) == 0);
      bus.fetchStall_i = stl;
      if (have_req) set_fetch(cur_a, m_pid[int'(cur_a[13:6])], 16'd3);
      else bus.fetchEnable_i = 0;
      step();
      if (!stl) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("stream_en", bus.outputEnable_o, 1);
          chk("stream_bundle", bus.outputBundle_o, e[127:0]);
          chk("stream_len", bus.bundleLen_o, e[130:128]);
          chk("stream_majid", bus.bundleStartMajId_o, e[194:131]);
          chk("stream_addr", bus.bundleAddress_o, e[258:195]);
        end else begin
          chk("stream_idle_en", bus.outputEnable_o, 0);
        end
        if (have_req) begin
          exp_q.push_back({cur_a, m_maj, 3'(m_len(int'(cur_a[5:2]))),
                           m_bundle(m_line[int'(cur_a[13:6])], int'(cur_a[5:2]))});
          m_maj += 64'(m_len(int'(cur_a[5:2])));
          issued++;
          have_req = 0;
        end
      end
    end
    bus.fetchStall_i = 0; bus.fetchEnable_i = 0;
    chk("stream_drained", 128'(exp_q.size()), 0);

    // Randomized mix of preloads, fetches and refills
    for (int i = 0; i < 60; i++) begin
      a = {50'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 6'($urandom_range(0, 63))};
      if ($urandom_range(0, 4) == 0) begin
        nat_write(a, rand_line(), 20'($urandom_range(5, 6)));
      end else begin
        lx[19:0] = 20'($urandom_range(5, 6));
        check_fetch("rnd", a, lx[19:0], 16'($urandom_range(0, 65535)), h);
        if (!h) begin
          refill(a, rand_line(), lx[19:0]);
          check_fetch("rnd_refetch", a, lx[19:0], 16'd9, h);
          chk("rnd_refetch_hit", h, 1);
        end
      end
    end

    // Reset clears every line and the major-ID counter
    rst_n = 0;
    step();
    chk("rst2_en", bus.outputEnable_o, 0);
    chk("rst2_majid", bus.bundleStartMajId_o, 0);
    rst_n = 1;
    for (int i = 0; i < 256; i++) m_valid[i] = 0;
    m_maj = '0;
    check_fetch("rst2_fetch", 64'h070, 20'd5, 16'd7, h);
    chk("rst2_is_miss", h, 0);
    refill(64'h070, PAT, 20'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
